// File: rtl/fft_stage_ctrl.sv
// Pass sequencer for an in-place radix-2 FFT over four banked RAMs: read/write
// addressing, bank crossbar selects, twiddle addressing and write alignment.
module fft_stage_ctrl #(
    parameter  int LOG2N = 8,
    parameter  int LAT   = 2,
    localparam int AW    = LOG2N - 2,
    localparam int SW    = $clog2(LOG2N)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] stage,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic          rd_swap,
    output logic [AW-1:0] tf_addr,
    output logic          bypass,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr_a,
    output logic [AW-1:0] wr_addr_b,
    output logic          wr_swap
);
    localparam int DEPTH = 1 << AW;
    localparam int NST   = LOG2N - 1;
    localparam int DW    = $clog2(LAT + 1);

    localparam logic [AW-1:0] LAST_RC = AW'(DEPTH - 1);
    localparam logic [DW-1:0] LAST_DC = DW'(LAT - 1);
    localparam logic [SW-1:0] LAST_ST = SW'(NST - 1);
    localparam logic [AW-1:0] ONES    = {AW{1'b1}};

    typedef enum logic [1:0] {IDLE, READ, DRAIN, NEXT} state_t;

    state_t        state, state_n;
    logic [AW-1:0] rc, rc_n;
    logic [DW-1:0] dc, dc_n;
    logic [SW-1:0] stage_n;
    logic          done_n;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            rc    <= '0;
            dc    <= '0;
            stage <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            rc    <= rc_n;
            dc    <= dc_n;
            stage <= stage_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        rc_n    = rc;
        dc_n    = dc;
        stage_n = stage;
        done_n  = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n = READ;
                stage_n = '0;
                rc_n    = '0;
            end
            READ: begin
                rc_n = rc + 1'b1;
                if (rc == LAST_RC) begin
                    state_n = DRAIN;
                    dc_n    = '0;
                end
            end
            DRAIN: begin
                dc_n = dc + 1'b1;
                if (dc == LAST_DC) state_n = NEXT;
            end
            NEXT: begin
                if (stage == LAST_ST) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n = READ;
                    stage_n = stage + 1'b1;
                    rc_n    = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // mask(s) has the top s bits set; the butterfly partner lives at index ^ mask.
    // Its lowest set bit picks the read swap bit, the top bit of ~mask the write one.
    logic [AW-1:0] mask, low, rd_sel, wr_sel;
    logic          rd_active;

    always_comb begin
        low    = ONES >> stage;
        mask   = ~low;
        rd_sel = mask & ~(mask << 1);
        wr_sel = low & ~(low >> 1);
    end

    assign rd_active = (state == READ);
    assign busy      = (state != IDLE);
    assign bypass    = busy && (stage == LAST_ST);

    always_comb begin
        rd_en     = rd_active;
        rd_addr_a = rd_active ? rc : '0;
        rd_addr_b = rd_active ? (rc ^ mask) : '0;
        rd_swap   = rd_active && |(rc & rd_sel);
        tf_addr   = rd_active ? (rc << stage) : '0;
    end

    // Read index and valid delayed by the read-to-write latency.
    logic [LAT:1]  vld_pipe;
    logic [AW-1:0] wc_pipe [LAT:1];
    logic [AW-1:0] wc;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_pipe <= '0;
            for (int i = 1; i <= LAT; i++) wc_pipe[i] <= '0;
        end else begin
            vld_pipe[1] <= rd_active;
            wc_pipe[1]  <= rd_addr_a;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                wc_pipe[i]  <= wc_pipe[i-1];
            end
        end
    end

    assign wc = wc_pipe[LAT];

    always_comb begin
        wr_en     = vld_pipe[LAT];
        wr_addr_a = wr_en ? wc : '0;
        wr_addr_b = wr_en ? (wc ^ mask) : '0;
        wr_swap   = wr_en && |(wc & wr_sel);
    end
endmodule
